// File: rtl/tdm_demux4_pkg.sv
// rtl/tdm_demux4_pkg.sv - shared constants and state encoding for the four-slot TDM demultiplexer
package tdm_demux4_pkg;

  localparam int SLOT_W = 2;
  localparam int NUM_CH = 4;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM demultiplexer with frame-lock FSM
// Distributes a frame-sync tagged sample stream into four held channel registers.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  state_e                              state_q, state_d;
  logic [SLOT_W-1:0]                   slot_q, slot_d;
  logic [NUM_CH-1:0][WIDTH-1:0]        ch_q, ch_d;
  logic [NUM_CH-1:0]                   ch_valid_q, ch_valid_d;
  logic                                frame_valid_q, frame_valid_d;
  logic                                sync_err_q, sync_err_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    ch_d          = ch_q;
    ch_valid_d    = '0;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (frame_sync) begin
            ch_d[0]    = din;
            ch_valid_d = 4'b0001;
            slot_d     = SLOT_W'(1);
            state_d    = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync) begin
            // An early sync restarts the frame at slot 0; the partial frame is lost.
            sync_err_d = (slot_q != '0);
            ch_d[0]    = din;
            ch_valid_d = 4'b0001;
            slot_d     = SLOT_W'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
          end else begin
            case (slot_q)
              2'd1: begin
                ch_d[1]    = din;
                ch_valid_d = 4'b0010;
              end
              2'd2: begin
                ch_d[2]    = din;
                ch_valid_d = 4'b0100;
              end
              default: begin
                ch_d[3]       = din;
                ch_valid_d    = 4'b1000;
                frame_valid_d = 1'b1;
              end
            endcase
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      slot_q        <= '0;
      ch_q          <= '0;
      ch_valid_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      ch_q          <= ch_d;
      ch_valid_q    <= ch_valid_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign ch_valid    = ch_valid_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic       frame_valid, sync_err, locked;

  int checks   = 0;
  int failures = 0;

  bit         m_locked;
  int         m_slot;
  logic [7:0] m_ch [4];
  logic [3:0] e_chv;
  logic       e_fv, e_err;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .ch_valid    (ch_valid),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: frame position as an integer, channels as an array.
  task automatic model(input bit rst, input bit v, input bit fs, input logic [7:0] d);
    e_chv = 4'b0;
    e_fv  = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_slot   = 0;
      for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
    end else if (v) begin
      if (fs) begin
        if (m_locked && m_slot != 0) e_err = 1'b1;
        m_ch[0]  = d;
        e_chv    = 4'b0001;
        m_slot   = 1;
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_slot == 0) begin
          e_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_ch[m_slot] = d;
          e_chv        = 4'(1 << m_slot);
          e_fv         = (m_slot == 3);
          m_slot       = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input bit fs, input logic [7:0] d);
    rst_n      = ~rst;
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    model(rst, v, fs, d);
    @(posedge clk);
    #1;
    chk("ch0", ch0, m_ch[0]);
    chk("ch1", ch1, m_ch[1]);
    chk("ch2", ch2, m_ch[2]);
    chk("ch3", ch3, m_ch[3]);
    chk("ch_valid", ch_valid, e_chv);
    chk("frame_valid", frame_valid, e_fv);
    chk("sync_err", sync_err, e_err);
    chk("locked", locked, m_locked);
  endtask

  task automatic smp(input bit fs, input logic [7:0] d);
    cyc(1'b0, 1'b1, fs, d);
  endtask

  task automatic gap(input int n, input bit fs);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, fs, 8'hEE);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;

    // Reset then a clean frame
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("reset_locked", locked, 1'b0);
    smp(1'b1, 8'h11); smp(1'b0, 8'h22); smp(1'b0, 8'h33); smp(1'b0, 8'h44);
    chk("s1_frame_ch3", ch3, 8'h44);

    // Hunt discard
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    smp(1'b0, 8'hAA); smp(1'b0, 8'hBB);
    chk("s2_ch0_untouched", ch0, 8'h00);
    smp(1'b1, 8'h01);
    chk("s2_ch0", ch0, 8'h01);

    // Early sync
    smp(1'b0, 8'h02); smp(1'b0, 8'h03); smp(1'b0, 8'h04);
    smp(1'b1, 8'h10); smp(1'b0, 8'h20);
    smp(1'b1, 8'h30);
    chk("s3_err", sync_err, 1'b1);
    smp(1'b0, 8'h40); smp(1'b0, 8'h50); smp(1'b0, 8'h60);
    chk("s3_fv", frame_valid, 1'b1);

    // Missing sync after a full frame
    smp(1'b0, 8'h77);
    chk("s4_ch0_kept", ch0, 8'h30);
    smp(1'b0, 8'h78);

    // Gaps, including a sync asserted without a valid sample
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    smp(1'b1, 8'h11); gap(3, 1'b1);
    smp(1'b0, 8'h22); gap(3, 1'b0);
    smp(1'b0, 8'h33); gap(3, 1'b1);
    smp(1'b0, 8'h44);
    chk("s5_ch2", ch2, 8'h33);

    // Reset mid-frame
    smp(1'b1, 8'h5A); smp(1'b0, 8'h6B);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    smp(1'b0, 8'h7C);
    chk("s6_ch1_cleared", ch1, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
